// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between fetch/resolve logic and the branch resolve queue.
// The master side issues and resolves branches; the slave side is the queue.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    logic                       req_valid;
    logic                       pred_in;
    logic                       req_ready;
    logic                       res_valid;
    logic                       res_taken;
    logic                       res_ready;
    logic                       flush;
    logic                       upd_result;
    logic                       upd_taken;
    logic                       mispredict;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic [CNT_W-1:0]           mispredict_cnt;
    logic                       underflow_err;

    modport master (
        output req_valid, pred_in, res_valid, res_taken, flush,
        input  req_ready, res_ready, upd_result, upd_taken, mispredict,
               count, mispredict_cnt, underflow_err
    );

    modport slave (
        input  req_valid, pred_in, res_valid, res_taken, flush,
        output req_ready, res_ready, upd_result, upd_taken, mispredict,
               count, mispredict_cnt, underflow_err
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of outstanding branch predictions. Each resolution is compared
// against the oldest stored prediction; the result trains the predictor through
// registered one-cycle pulses and feeds a saturating mispredict counter.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    branch_resolve_queue_if.slave io_brq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic             r_upd_result;
    logic             r_upd_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_mis_cnt;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic             w_head;
    logic             w_miss;

    // Occupancy flags, handshakes and head comparison; flush and reset suppress
    // both enqueue and dequeue so a flushed cycle produces no training pulse.
    always_comb begin
        w_full  = (r_count == OCC_W'(DEPTH));
        w_empty = (r_count == '0);
        w_enq   = io_brq.req_valid && !w_full && !io_brq.flush && !i_rst;
        w_deq   = io_brq.res_valid && !w_empty && !io_brq.flush && !i_rst;
        w_head  = r_mem[r_rd_ptr];
        w_miss  = (w_head != io_brq.res_taken);
    end

    // Prediction storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_enq)
            r_mem[r_wr_ptr] <= io_brq.pred_in;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst || io_brq.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered training pulses, one cycle after each accepted resolution.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_upd_result <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd_result <= w_deq;
            r_upd_taken  <= w_deq && io_brq.res_taken;
            r_mispredict <= w_deq && w_miss;
        end
    end

    // Performance counter and sticky underflow flag; both survive a flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mis_cnt   <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_deq && w_miss && (r_mis_cnt != {CNT_W{1'b1}}))
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            if (io_brq.res_valid && w_empty)
                r_underflow <= 1'b1;
        end
    end

    // Output drive; the ready flags are combinational from occupancy.
    always_comb begin
        io_brq.req_ready      = !w_full;
        io_brq.res_ready      = !w_empty;
        io_brq.upd_result     = r_upd_result;
        io_brq.upd_taken      = r_upd_taken;
        io_brq.mispredict     = r_mispredict;
        io_brq.count          = r_count;
        io_brq.mispredict_cnt = r_mis_cnt;
        io_brq.underflow_err  = r_underflow;
    end
endmodule
